onehot_stream_demux: RTL and testbench

- Distribution-side counterpart of the one-hot data mux: steers one valid/ready input stream to exactly one of N output streams under a one-hot select.
- Optional per-output elastic buffering decouples back-pressure between lanes.
- Used at dispatch/issue fan-out points where one producer feeds N consumers, e.g. warp-to-execute-unit or request-to-bank routing.

---
 rtl/onehot_stream_demux_pkg.sv | 30 +++
 rtl/onehot_skid_buf.sv | 64 ++++++
 rtl/onehot_stream_demux.sv | 92 +++++++++
 tb/tb_onehot_stream_demux.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_stream_demux_pkg.sv
// Shared constants, buffer state encoding and select-decoding helpers for the
// one-hot stream demultiplexer.
package onehot_stream_demux_pkg;

    localparam int unsigned BUF_NONE = 0;
    localparam int unsigned BUF_SKID = 1;

    // Select helpers operate on a zero-extended copy of sel_in.
    localparam int unsigned MAX_N = 32;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } buf_state_e;

    function automatic logic is_onehot(logic [MAX_N-1:0] sel);
        return (sel != '0) && ((sel & (sel - MAX_N'(1))) == '0);
    endfunction

    function automatic int unsigned lowest_set_idx(logic [MAX_N-1:0] sel);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (sel[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// Two-entry skid buffer: registered output stage plus one overflow entry.
// Ready depends only on state, so ready_out never reaches ready_in combinationally.
module onehot_skid_buf
    import onehot_stream_demux_pkg::*;
#(
    parameter int unsigned DATAW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [DATAW-1:0] data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [DATAW-1:0] data_out,
    input  logic             ready_out
);

    buf_state_e       state_q;
    logic [DATAW-1:0] out_q;
    logic [DATAW-1:0] skid_q;
    logic             push;
    logic             pop;

    assign ready_in  = (state_q != StFull);
    assign valid_out = (state_q != StEmpty);
    assign data_out  = out_q;
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        out_q   <= data_in;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        out_q <= data_in;
                    end else if (push) begin
                        skid_q  <= data_in;
                        state_q <= StFull;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        out_q   <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: rtl/onehot_stream_demux.sv
// Steers one valid/ready stream to one of N lanes under a one-hot select,
// with optional per-lane skid buffering and a sticky illegal-select flag.
module onehot_stream_demux
    import onehot_stream_demux_pkg::*;
#(
    parameter int unsigned DATAW   = 1,
    parameter int unsigned N       = 2,
    parameter int unsigned OUT_BUF = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               valid_in,
    input  logic [DATAW-1:0]   data_in,
    input  logic [N-1:0]       sel_in,
    output logic               ready_in,
    output logic [N-1:0]       valid_out,
    output logic [N*DATAW-1:0] data_out,
    input  logic [N-1:0]       ready_out,
    output logic               sel_err
);

    logic [N-1:0] lane_sel;
    logic [N-1:0] lane_ready;
    logic [N-1:0] lane_valid;
    logic         sel_zero;
    logic         sel_multi;
    logic         sel_err_q;

    if (N == 1) begin : g_single
        logic unused_sel;
        assign unused_sel = ^sel_in;
        assign lane_sel   = '1;
        assign sel_zero   = 1'b0;
        assign sel_multi  = 1'b0;
    end else begin : g_multi
        logic [MAX_N-1:0] sel_ext;
        int unsigned      sel_idx;

        assign sel_ext   = MAX_N'(sel_in);
        assign sel_idx   = lowest_set_idx(sel_ext);
        assign sel_zero  = (sel_in == '0);
        assign sel_multi = !sel_zero && !is_onehot(sel_ext);

        // Multi-hot resolves to the lowest set lane.
        always_comb begin
            lane_sel = '0;
            for (int i = 0; i < int'(N); i++) begin
                lane_sel[i] = !sel_zero && (sel_idx == unsigned'(i));
            end
        end
    end

    // A zero select swallows the beat, so it is always ready.
    assign ready_in   = sel_zero || |(lane_sel & lane_ready);
    assign lane_valid = valid_in ? lane_sel : '0;

    if (OUT_BUF == BUF_SKID) begin : g_buf
        for (genvar i = 0; i < int'(N); i++) begin : g_lane
            onehot_skid_buf #(
                .DATAW(DATAW)
            ) u_buf (
                .clk      (clk),
                .reset_n  (reset_n),
                .valid_in (lane_valid[i]),
                .data_in  (data_in),
                .ready_in (lane_ready[i]),
                .valid_out(valid_out[i]),
                .data_out (data_out[i*DATAW +: DATAW]),
                .ready_out(ready_out[i])
            );
        end
    end else begin : g_wire
        assign lane_ready = ready_out;
        assign valid_out  = lane_valid;
        assign data_out   = {N{data_in}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else if (valid_in && ready_in && (sel_zero || sel_multi)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;

    multi_hot_sel: assert property (@(posedge clk) disable iff (!reset_n)
        !(valid_in && sel_multi))
        else $warning("onehot_stream_demux: multi-hot sel_in %b", sel_in);

endmodule

// File: tb/tb_onehot_stream_demux.sv
// Randomised and directed checks of onehot_stream_demux against a queue-based lane model.
module tb_onehot_stream_demux;

    localparam int DW = 8;
    localparam int NL = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             valid_in = 1'b0;
    logic [DW-1:0]    data_in = '0;
    logic [NL-1:0]    sel_in = '0;
    logic             ready_in;
    logic [NL-1:0]    valid_out;
    logic [NL*DW-1:0] data_out;
    logic [NL-1:0]    ready_out = '0;
    logic             sel_err;

    logic             pt_valid_in = 1'b0;
    logic [DW-1:0]    pt_data_in = '0;
    logic [NL-1:0]    pt_sel_in = '0;
    logic             pt_ready_in;
    logic [NL-1:0]    pt_valid_out;
    logic [NL*DW-1:0] pt_data_out;
    logic [NL-1:0]    pt_ready_out = '0;
    logic             pt_sel_err;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [DW-1:0] mq [NL][$];
    logic          err_m = 1'b0;

    always #5 clk = ~clk;

    onehot_stream_demux #(.DATAW(DW), .N(NL), .OUT_BUF(1)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in),
        .sel_in(sel_in), .ready_in(ready_in), .valid_out(valid_out),
        .data_out(data_out), .ready_out(ready_out), .sel_err(sel_err)
    );

    onehot_stream_demux #(.DATAW(DW), .N(NL), .OUT_BUF(0)) dut_pt (
        .clk(clk), .reset_n(reset_n), .valid_in(pt_valid_in), .data_in(pt_data_in),
        .sel_in(pt_sel_in), .ready_in(pt_ready_in), .valid_out(pt_valid_out),
        .data_out(pt_data_out), .ready_out(pt_ready_out), .sel_err(pt_sel_err)
    );

    function automatic int lowest(logic [NL-1:0] s);
        for (int i = 0; i < NL; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic logic [NL-1:0] exp_valid();
        logic [NL-1:0] v;
        for (int i = 0; i < NL; i++) v[i] = (mq[i].size() > 0);
        return v;
    endfunction

    function automatic logic [NL*DW-1:0] exp_data();
        logic [NL*DW-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++) if (mq[i].size() > 0) d[i*DW +: DW] = mq[i][0];
        return d;
    endfunction

    // Lanes that are not valid carry don't-care data; blank them before comparing.
    function automatic logic [NL*DW-1:0] dut_data();
        logic [NL*DW-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++) if (valid_out[i]) d[i*DW +: DW] = data_out[i*DW +: DW];
        return d;
    endfunction

    function automatic logic exp_ready();
        int l;
        l = lowest(sel_in);
        if (l < 0) return 1'b1;
        return mq[l].size() < 2;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mq[i].delete();
        err_m = 1'b0;
    endtask

    // Advance one clock; the model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        int   l;
        logic acc;
        @(posedge clk);
        l   = lowest(sel_in);
        acc = reset_n && valid_in && exp_ready();
        for (int i = 0; i < NL; i++) begin
            if (mq[i].size() > 0 && ready_out[i]) void'(mq[i].pop_front());
        end
        if (acc) begin
            if (l < 0 || $countones(sel_in) > 1) err_m = 1'b1;
            if (l >= 0) mq[l].push_back(data_in);
        end
        #1;
    endtask

    task automatic apply_reset();
        valid_in  = 1'b0;
        sel_in    = '0;
        data_in   = '0;
        ready_out = '0;
        reset_n   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        sel_in    = 4'b0001;
        ready_out = '1;
        #2;
        chk_cnt++;
        if ({ready_in, valid_out, sel_err} !== {1'b1, 4'b0000, 1'b0})
            $display("FAIL reset: got rdy=%b vld=%b err=%b, want rdy=1 vld=0000 err=0",
                     ready_in, valid_out, sel_err);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_steering();
        logic [11:0] tbl [3] = '{{8'hA1, 4'b0001}, {8'hB2, 4'b0100}, {8'hC3, 4'b1000}};
        ready_out = '1;
        for (int k = 0; k < 6; k++) begin
            valid_in = (k < 3);
            {data_in, sel_in} = (k < 3) ? tbl[k] : {8'h00, 4'b0001};
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL steer c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", k,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            if (k == 1) begin
                chk_cnt++;
                if (!(valid_out[0] && data_out[7:0] == 8'hA1))
                    $display("FAIL steer_lane0: got v=%b d=%h, want v=1 d=a1",
                             valid_out[0], data_out[7:0]);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        // {valid, sel, data, ready_out}
        logic [16:0] tbl [8] = '{
            {1'b1, 4'b0010, 8'h11, 4'b1101}, {1'b1, 4'b0010, 8'h12, 4'b1101},
            {1'b1, 4'b0001, 8'h20, 4'b1101}, {1'b1, 4'b0010, 8'h13, 4'b1101},
            {1'b1, 4'b0010, 8'h13, 4'b1111}, {1'b1, 4'b0010, 8'h13, 4'b1111},
            {1'b0, 4'b0010, 8'h00, 4'b1111}, {1'b0, 4'b0010, 8'h00, 4'b1111}};
        for (int k = 0; k < 8; k++) begin
            {valid_in, sel_in, data_in, ready_out} = tbl[k];
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL backpr c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", k,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            if (k == 3) begin
                chk_cnt++;
                if (ready_in !== 1'b0)
                    $display("FAIL backpr_stall: got rdy=%b, want rdy=0", ready_in);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_throughput();
        logic [DW-1:0] got [$];
        int            nxt;
        int            cyc;
        logic          ok;
        nxt = 0;
        cyc = 0;
        sel_in = 4'b0100;
        while ((nxt < 16 || got.size() < 16) && cyc < 100) begin
            valid_in  = (nxt < 16);
            data_in   = DW'(nxt);
            ready_out = {1'b1, (cyc % 2 == 0), 2'b11};
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL thru c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", cyc,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            if (valid_out[2] && ready_out[2]) got.push_back(data_out[2*DW +: DW]);
            if (valid_in && ready_in) nxt++;
            tick();
            cyc++;
        end
        ok = (got.size() == 16);
        for (int i = 0; i < got.size() && i < 16; i++) if (got[i] !== DW'(i)) ok = 1'b0;
        chk_cnt++;
        if (!ok)
            $display("FAIL thru_order: got %0d beats after %0d cycles, want 0..15 in order",
                     got.size(), cyc);
        else pass_cnt++;
        valid_in  = 1'b0;
        ready_out = '1;
        tick();
    endtask

    task automatic test_sel_zero();
        ready_out = '1;
        for (int k = 0; k < 3; k++) begin
            valid_in = (k == 0);
            sel_in   = (k == 0) ? 4'b0000 : 4'b0001;
            data_in  = 8'h55;
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL selzero c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", k,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if ({sel_err, valid_out} !== {1'b1, 4'b0000})
            $display("FAIL selzero_sticky: got err=%b vld=%b, want err=1 vld=0000",
                     sel_err, valid_out);
        else pass_cnt++;
    endtask

    task automatic test_multihot();
        apply_reset();
        ready_out = '1;
        for (int k = 0; k < 2; k++) begin
            valid_in = (k == 0);
            sel_in   = 4'b0110;
            data_in  = 8'h66;
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL multihot c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", k,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            if (k == 1) begin
                chk_cnt++;
                if ({valid_out, data_out[DW +: DW], sel_err} !== {4'b0010, 8'h66, 1'b1})
                    $display("FAIL multihot_lane1: got vld=%b d=%h err=%b, want 0010 66 1",
                             valid_out, data_out[DW +: DW], sel_err);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ready_out = 4'b1101;
        sel_in    = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            valid_in = (k < 2);
            data_in  = 8'h30 + DW'(k);
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL areset c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", k,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            if (k < 2) tick();
        end
        // Lane1 is full here; pull reset between edges.
        reset_n = 1'b0;
        model_clear();
        #1;
        chk_cnt++;
        if ({valid_out, sel_err} !== {4'b0000, 1'b0})
            $display("FAIL areset_drop: got vld=%b err=%b, want vld=0000 err=0",
                     valid_out, sel_err);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        ready_out = '1;
        for (int k = 0; k < 2; k++) begin
            valid_in = (k == 0);
            sel_in   = 4'b1000;
            data_in  = 8'h77;
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL areset_after c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h",
                         k, ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_passthrough();
        pt_valid_in  = 1'b1;
        pt_sel_in    = 4'b0010;
        pt_data_in   = DW'($urandom);
        pt_ready_out = 4'b0010;
        #1;
        chk_cnt++;
        if ({pt_valid_out, pt_ready_in, pt_data_out[DW +: DW]} !== {4'b0010, 1'b1, pt_data_in})
            $display("FAIL pass_route: got vld=%b rdy=%b d=%h, want 0010 1 %h",
                     pt_valid_out, pt_ready_in, pt_data_out[DW +: DW], pt_data_in);
        else pass_cnt++;
        pt_ready_out = 4'b1101;
        #1;
        chk_cnt++;
        if ({pt_valid_out, pt_ready_in} !== {4'b0010, 1'b0})
            $display("FAIL pass_stall: got vld=%b rdy=%b, want vld=0010 rdy=0",
                     pt_valid_out, pt_ready_in);
        else pass_cnt++;
        pt_valid_in = 1'b0;
        #1;
        chk_cnt++;
        if (pt_valid_out !== 4'b0000)
            $display("FAIL pass_idle: got vld=%b, want 0000", pt_valid_out);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            r         = int'($urandom_range(0, 9));
            valid_in  = ($urandom_range(0, 3) != 0);
            sel_in    = (r == 0) ? 4'b0000 : 4'b0001 << $urandom_range(0, NL - 1);
            data_in   = DW'($urandom);
            ready_out = NL'($urandom);
            #2;
            chk_cnt++;
            if ({ready_in, valid_out, sel_err} !== {exp_ready(), exp_valid(), err_m} ||
                dut_data() !== exp_data())
                $display("FAIL random c%0d: got rdy=%b vld=%b err=%b d=%h, want %b %b %b %h", k,
                         ready_in, valid_out, sel_err, dut_data(),
                         exp_ready(), exp_valid(), err_m, exp_data());
            else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_steering();
        test_backpressure();
        test_throughput();
        test_sel_zero();
        test_multihot();
        test_async_reset();
        test_passthrough();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
